// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ valid/ready requesters.
// Each grant lasts at most MAX_BURST beats, and there is a one-cycle idle bubble between grants.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_w_en,
    output logic [WIDTH-1:0]        fifo_din,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic [GW-1:0] grant_n, last_grant, last_grant_n, sel;

    // Walk the offsets from farthest to nearest, so the requester nearest after last_grant wins.
    always_comb begin
        sel = last_grant;
        for (int i = NREQ; i >= 1; i--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req_valid[j] && (j == (int'(last_grant) + i) % NREQ)) begin
                    sel = GW'(j);
                end
            end
        end
    end

    // NOTE: Every signal gets its default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        state_n      = state;
        beat_cnt_n   = beat_cnt;
        grant_n      = grant_id;
        last_grant_n = last_grant;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n      = GRANT;
                    beat_cnt_n   = '0;
                    grant_n      = sel;
                    last_grant_n = sel;
                end
            end
            GRANT: begin
                // While the FIFO is full, the grant and the beat count stay frozen.
                if (!fifo_full) begin
                    if (!req_valid[grant_id] || beat_cnt == LAST_BEAT) begin
                        state_n    = IDLE;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: Non-blocking assignments, so every register samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_cnt_n;
            grant_id   <= grant_n;
            last_grant <= last_grant_n;
        end
    end

    // The outputs decode only the registered state, so an asynchronous reset clears them at once.
    always_comb begin
        busy      = (state == GRANT);
        fifo_w_en = busy & req_valid[grant_id] & ~fifo_full;
        req_ready = '0;
        if (busy && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
        fifo_din = fifo_w_en ? req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port among NREQ requesters. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst, steers its data onto the FIFO write port, and backpressures on FIFO full. It sits directly in front of the FIFO's w_en/din/full interface.

Parameters:
WIDTH, 4, data width in bits; equals the FIFO data width.
NREQ, 4, number of requesters; legal range 2..8.
MAX_BURST, 4, maximum beats accepted per grant; legal range 1..16.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester data valid.
req_data  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
req_ready  output  NREQ  per-requester accept; one-hot or zero.
fifo_full  input  1  FIFO full flag.
fifo_w_en  output  1  FIFO write enable.
fifo_din  output  WIDTH  FIFO write data.
grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
busy  output  1  high while in GRANT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, beat_cnt=0, grant_id=0, last_grant=NREQ-1, so requester 0 has first priority.
  - busy=0, req_ready=0, fifo_w_en=0, fifo_din=0.
  - Reset asserted mid-burst aborts the burst immediately. No partial write occurs in the cycle reset is low.
- States: IDLE, GRANT.
- IDLE:
  - busy=0; req_ready=0; fifo_w_en=0.
  - If any req_valid is high, select the first set bit searching from (last_grant+1) mod NREQ upward with wrap-around.
  - Registers: grant_id <= selected, last_grant <= selected, beat_cnt <= 0, state <= GRANT.
  - Arbitration latency is 1 cycle: the first transfer can occur in the cycle after the request is seen.
- GRANT, with g = grant_id:
  - busy=1.
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - fifo_w_en = req_valid[g] & ~fifo_full (combinational).
  - fifo_din = req_data[g] when fifo_w_en=1, else 0.
  - A transfer is a cycle with fifo_w_en=1. Each transfer increments beat_cnt.
- GRANT exit conditions:
  - Transfer with beat_cnt==MAX_BURST-1: go to IDLE.
  - req_valid[g]=0 while fifo_full=0: go to IDLE; the requester has released.
  - fifo_full=1: hold GRANT and beat_cnt regardless of req_valid[g]. No timeout.
- Re-arbitration: from IDLE only, so there is a 1-cycle bubble between grants. Fairness: a continuously requesting set of requesters is served in strict rotation.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
  - For non-power-of-2 NREQ, the rotation pointer wraps modulo NREQ.
- Invariants:
  - fifo_w_en is never 1 while fifo_full=1.
  - At most one req_ready bit is high.
  - Data is never duplicated or dropped: every cycle with req_valid[i]&req_ready[i] produces exactly one fifo_w_en pulse carrying req_data[i].

Test Plan:
1. Reset and first request: assert and release reset; hold req_valid=4'b0001, fifo_full=0, requester 0 streaming data 1,2,3,4,5. Expect grant_id=0 one cycle after request; writes 1,2,3,4 on consecutive cycles; IDLE for 1 cycle; then regrant 0 and write 5.
2. Round-robin rotation: all four requesters constantly valid, MAX_BURST=4. Expect grant order 0,1,2,3,0; each grant writes 4 beats; one idle bubble between grants.
3. Full backpressure: mid-burst, after 2 beats, hold fifo_full=1 for 3 cycles. Expect fifo_w_en=0 and req_ready=0 during those cycles; grant held; remaining 2 beats written after full deasserts; total 4 beats.
4. Early release: requester 2 granted, sends 1 beat, then drops valid. Expect return to IDLE next cycle; beat_cnt reset; next grant goes to requester 3 if valid, else wraps to 0.
5. Wrap and skip: req_valid=4'b1001 with last_grant=0. Expect grant 3, then 0, then 3.
6. Async reset mid-burst: pull reset low between clock edges during GRANT. Expect busy, fifo_w_en and req_ready to go 0 immediately without waiting for a clock edge; after release, requester 0 has priority.
